gelato_simd_alu: RTL and testbench

Multi-lane, parametrised arithmetic logic unit for the Gelato compute core. It replaces the single-lane, ADD-only ALU and sits between the issue stage and writeback. It accepts one warp-wide operation per handshake, applies it to `NUM_LANES` lanes under an active mask, and returns a tagged, masked result. It supports single-cycle logic and arithmetic ops plus an iterative multi-cycle multiply, and flags illegal opcodes instead of halting simulation.

---
 rtl/gelato_simd_alu_pkg.sv | 31 +++
 rtl/gelato_simd_alu_if.sv | 38 +++
 rtl/gelato_simd_alu_lane.sv | 69 ++++++
 rtl/gelato_simd_alu.sv | 105 ++++++++++
 tb/tb_gelato_simd_alu.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/gelato_simd_alu_pkg.sv
// Shared Gelato type package: ALU opcodes, ALU FSM states and the opcode
// legality helper used by the SIMD ALU.
package gelato_types;

  typedef enum logic [3:0] {
    ADD  = 4'd0,
    SUB  = 4'd1,
    AND  = 4'd2,
    OR   = 4'd3,
    XOR  = 4'd4,
    SLL  = 4'd5,
    SRL  = 4'd6,
    SRA  = 4'd7,
    SLT  = 4'd8,
    SLTU = 4'd9,
    MUL  = 4'd10
  } alu_op_t;

  // State names carry a prefix so they do not collide with the MUL opcode.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_RESP = 2'd2
  } alu_state_t;

  // Encodings above MUL are unused and flagged as illegal on the response.
  function automatic logic op_legal(input alu_op_t op);
    return (op <= MUL);
  endfunction

endpackage

// File: rtl/gelato_simd_alu_if.sv
// Issue -> ALU -> writeback bus for the SIMD ALU.
//   master : issue/writeback side (drives requests, consumes responses)
//   slave  : the ALU
// Lane i of every wide vector occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
interface gelato_simd_alu_if
  import gelato_types::*;
#(
  parameter int NUM_LANES  = 4,
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 4
) ();

  logic                            req_valid;
  logic                            req_ready;
  alu_op_t                         req_op;
  logic [NUM_LANES-1:0]            req_mask;
  logic [NUM_LANES*DATA_WIDTH-1:0] req_rs1;
  logic [NUM_LANES*DATA_WIDTH-1:0] req_rs2;
  logic [TAG_WIDTH-1:0]            req_tag;

  logic                            resp_valid;
  logic                            resp_ready;
  logic [NUM_LANES*DATA_WIDTH-1:0] resp_rd;
  logic [NUM_LANES-1:0]            resp_mask;
  logic [TAG_WIDTH-1:0]            resp_tag;
  logic                            resp_err;

  modport master (
    output req_valid, req_op, req_mask, req_rs1, req_rs2, req_tag, resp_ready,
    input  req_ready, resp_valid, resp_rd, resp_mask, resp_tag, resp_err
  );

  modport slave (
    input  req_valid, req_op, req_mask, req_rs1, req_rs2, req_tag, resp_ready,
    output req_ready, resp_valid, resp_rd, resp_mask, resp_tag, resp_err
  );

endinterface

// File: rtl/gelato_simd_alu_lane.sv
// One SIMD ALU lane.
//   clk, rst_n : clock, async active-low reset
//   op         : operation for the combinational datapath
//   rs1, rs2   : lane operands
//   mul_load   : latch operands into the multiplier, clear accumulator
//   mul_step   : perform one shift-add iteration
//   alu_res    : single-cycle result (0 for MUL and illegal opcodes)
//   mul_res    : accumulator value after the current iteration's add
module gelato_alu_lane
  import gelato_types::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  alu_op_t               op,
  input  logic [DATA_WIDTH-1:0] rs1,
  input  logic [DATA_WIDTH-1:0] rs2,
  input  logic                  mul_load,
  input  logic                  mul_step,
  output logic [DATA_WIDTH-1:0] alu_res,
  output logic [DATA_WIDTH-1:0] mul_res
);

  localparam int SHW = $clog2(DATA_WIDTH);

  logic [SHW-1:0]        sh;
  logic [DATA_WIDTH-1:0] mcand, mplier, acc;

  assign sh = rs2[SHW-1:0];

  always_comb begin
    alu_res = '0;
    case (op)
      ADD:     alu_res = rs1 + rs2;
      SUB:     alu_res = rs1 - rs2;
      AND:     alu_res = rs1 & rs2;
      OR:      alu_res = rs1 | rs2;
      XOR:     alu_res = rs1 ^ rs2;
      SLL:     alu_res = rs1 << sh;
      SRL:     alu_res = rs1 >> sh;
      SRA:     alu_res = DATA_WIDTH'($signed(rs1) >>> sh);
      SLT:     alu_res = DATA_WIDTH'($signed(rs1) < $signed(rs2));
      SLTU:    alu_res = DATA_WIDTH'(rs1 < rs2);
      default: alu_res = '0;
    endcase
  end

  // Only the low DATA_WIDTH product bits are kept, so the multiplicand can
  // simply shift out of the top without widening.
  assign mul_res = acc + (mplier[0] ? mcand : '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
    end else if (mul_load) begin
      mcand  <= rs1;
      mplier <= rs2;
      acc    <= '0;
    end else if (mul_step) begin
      acc    <= mul_res;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
    end
  end

endmodule

// File: rtl/gelato_simd_alu.sv
// Gelato SIMD ALU top: warp-wide op under an active mask, tagged response.
//   clk, rst_n : clock, async active-low reset
//   rdy        : global enable; low freezes all state and blocks handshakes
//   bus        : request/response bus (slave side)
// Single-cycle ops respond one edge after accept; MUL iterates DATA_WIDTH
// enabled cycles through the per-lane shift-add multipliers.
module gelato_simd_alu
  import gelato_types::*;
#(
  parameter int NUM_LANES  = 4,
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 4
) (
  input logic              clk,
  input logic              rst_n,
  input logic              rdy,
  gelato_simd_alu_if.slave bus
);

  localparam int CW = $clog2(DATA_WIDTH) + 1;

  alu_state_t                           state_q, state_d;
  logic [CW-1:0]                        cnt_q;
  logic                                 accept, is_mul, legal, mul_step, mul_done;
  logic [NUM_LANES-1:0][DATA_WIDTH-1:0] alu_res, mul_res, rd_q;
  logic [NUM_LANES-1:0]                 mask_q;
  logic [TAG_WIDTH-1:0]                 tag_q;
  logic                                 err_q;

  assign is_mul   = (bus.req_op == MUL);
  assign legal    = op_legal(bus.req_op);
  assign mul_step = rdy && (state_q == ST_MUL);
  assign mul_done = mul_step && (cnt_q == CW'(1));

  assign bus.req_ready = rdy && ((state_q == ST_IDLE) ||
                                 (state_q == ST_RESP && bus.resp_ready));
  assign accept        = bus.req_valid && bus.req_ready;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    gelato_alu_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
      .clk      (clk),
      .rst_n    (rst_n),
      .op       (bus.req_op),
      .rs1      (bus.req_rs1[i*DATA_WIDTH +: DATA_WIDTH]),
      .rs2      (bus.req_rs2[i*DATA_WIDTH +: DATA_WIDTH]),
      .mul_load (accept && is_mul),
      .mul_step (mul_step),
      .alu_res  (alu_res[i]),
      .mul_res  (mul_res[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // req_ready already folds in rdy, so accept never fires while frozen.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = is_mul ? ST_MUL : ST_RESP;
      ST_MUL:  if (mul_done) state_d = ST_RESP;
      ST_RESP: begin
        if (accept)                    state_d = is_mul ? ST_MUL : ST_RESP;
        else if (rdy && bus.resp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      rd_q   <= '0;
      mask_q <= '0;
      tag_q  <= '0;
      err_q  <= 1'b0;
    end else if (accept) begin
      mask_q <= bus.req_mask;
      tag_q  <= bus.req_tag;
      err_q  <= !legal;
      if (is_mul) begin
        cnt_q <= CW'(DATA_WIDTH);
      end else begin
        for (int i = 0; i < NUM_LANES; i++)
          rd_q[i] <= (bus.req_mask[i] && legal) ? alu_res[i] : '0;
      end
    end else if (mul_step) begin
      cnt_q <= cnt_q - CW'(1);
      // Final iteration: capture the post-add accumulator straight into rd.
      if (mul_done) begin
        for (int i = 0; i < NUM_LANES; i++)
          rd_q[i] <= mask_q[i] ? mul_res[i] : '0;
      end
    end
  end

  assign bus.resp_valid = (state_q == ST_RESP);
  assign bus.resp_rd    = rd_q;
  assign bus.resp_mask  = mask_q;
  assign bus.resp_tag   = tag_q;
  assign bus.resp_err   = err_q;

endmodule

// File: tb/tb_gelato_simd_alu.sv
module tb_gelato_simd_alu;
  import gelato_types::*;

  localparam int NL = 4;
  localparam int DW = 32;
  localparam int TW = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic rdy   = 1'b0;

  gelato_simd_alu_if #(.NUM_LANES(NL), .DATA_WIDTH(DW), .TAG_WIDTH(TW)) bus ();

  gelato_simd_alu #(.NUM_LANES(NL), .DATA_WIDTH(DW), .TAG_WIDTH(TW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .rdy   (rdy),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] op, input logic [3:0] mask,
                       input logic [127:0] a, input logic [127:0] b,
                       input logic [3:0] tag);
    bus.req_valid = 1'b1;
    bus.req_op    = alu_op_t'(op);
    bus.req_mask  = mask;
    bus.req_rs1   = a;
    bus.req_rs2   = b;
    bus.req_tag   = tag;
  endtask

  int got_c;

  initial begin
    bus.req_valid  = 1'b0;
    bus.req_op     = ADD;
    bus.req_mask   = '0;
    bus.req_rs1    = '0;
    bus.req_rs2    = '0;
    bus.req_tag    = '0;
    bus.resp_ready = 1'b0;
    rdy            = 1'b1;
    rst_n          = 1'b0;

    // reset state
    #12;
    chk("rst_valid", bus.resp_valid, 0);
    chk("rst_rd",    bus.resp_rd,    0);
    chk("rst_mask",  bus.resp_mask,  0);
    chk("rst_tag",   bus.resp_tag,   0);
    chk("rst_err",   bus.resp_err,   0);
    chk("rst_ready", bus.req_ready,  1);
    rst_n = 1'b1;
    tick();

    // ADD with wrap, response held while resp_ready low
    drive(ADD, 4'hF, {32'h100, 32'd10, 32'hFFFF_FFFF, 32'd5},
                     {32'h1,   32'd20, 32'h1,         32'd7}, 4'd3);
    tick();
    bus.req_valid = 1'b0;
    chk("add_valid", bus.resp_valid, 1);
    chk("add_rd",    bus.resp_rd, {32'h101, 32'd30, 32'd0, 32'd12});
    chk("add_tag",   bus.resp_tag, 3);
    chk("add_err",   bus.resp_err, 0);
    chk("add_mask",  bus.resp_mask, 4'hF);
    chk("add_hold_ready", bus.req_ready, 0);
    tick();
    chk("add_hold_rd", bus.resp_rd, {32'h101, 32'd30, 32'd0, 32'd12});
    bus.resp_ready = 1'b1;
    #1;
    chk("add_rel_ready", bus.req_ready, 1);
    tick();
    chk("add_drain", bus.resp_valid, 0);

    // masked SUB, shifts, compares, logic
    drive(SUB, 4'b0101, {4{32'd3}}, {4{32'd5}}, 4'd1);
    tick();
    chk("sub_mask", bus.resp_rd, {32'd0, 32'hFFFF_FFFE, 32'd0, 32'hFFFF_FFFE});
    drive(SRA, 4'b0011, {32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFF0, 32'h8000_0000},
                        {32'd1, 32'd1, 32'd4, 32'd35}, 4'd2);
    tick();
    chk("sra", bus.resp_rd, {32'd0, 32'd0, 32'h07FF_FFFF, 32'hF000_0000});
    chk("sra_tag", bus.resp_tag, 2);
    drive(SRL, 4'b0001, {96'd0, 32'h8000_0000}, {96'd0, 32'd35}, 4'd3);
    tick();
    chk("srl", bus.resp_rd, {96'd0, 32'h1000_0000});
    drive(SLL, 4'b0001, {96'd0, 32'd1}, {96'd0, 32'd31}, 4'd4);
    tick();
    chk("sll", bus.resp_rd, {96'd0, 32'h8000_0000});
    drive(SLT, 4'hF, {32'd1, 32'h8000_0000, 32'd5, 32'hFFFF_FFFF},
                     {32'd2, 32'h7FFF_FFFF, 32'd3, 32'd1}, 4'd5);
    tick();
    chk("slt", bus.resp_rd, {32'd1, 32'd1, 32'd0, 32'd1});
    drive(SLTU, 4'hF, {32'd1, 32'h8000_0000, 32'd5, 32'hFFFF_FFFF},
                      {32'd2, 32'h7FFF_FFFF, 32'd3, 32'd1}, 4'd6);
    tick();
    chk("sltu", bus.resp_rd, {32'd1, 32'd0, 32'd0, 32'd0});
    drive(AND, 4'b0001, {96'd0, 32'hF0F0_F0F0}, {96'd0, 32'hFF00_FF00}, 4'd7);
    tick();
    chk("and", bus.resp_rd, {96'd0, 32'hF000_F000});
    drive(OR, 4'b0001, {96'd0, 32'hF0F0_F0F0}, {96'd0, 32'hFF00_FF00}, 4'd7);
    tick();
    chk("or", bus.resp_rd, {96'd0, 32'hFFF0_FFF0});
    drive(XOR, 4'b0001, {96'd0, 32'hF0F0_F0F0}, {96'd0, 32'hFF00_FF00}, 4'd7);
    tick();
    chk("xor", bus.resp_rd, {96'd0, 32'h0FF0_0FF0});
    bus.req_valid = 1'b0;
    tick();
    chk("logic_drain", bus.resp_valid, 0);

    // MUL: 32-cycle latency, second request held off then overlaps the drain
    bus.resp_ready = 1'b0;
    drive(MUL, 4'b0111, {32'd7, 32'h0001_0000, 32'hFFFF_FFFF, 32'h0001_0003},
                        {32'd6, 32'h0001_0000, 32'hFFFF_FFFF, 32'd5}, 4'd5);
    tick();
    drive(ADD, 4'hF, {4{32'd2}}, {4{32'd2}}, 4'd9);
    for (int i = 0; i < 31; i++) begin
      chk("mul_busy_ready", bus.req_ready, 0);
      chk("mul_busy_valid", bus.resp_valid, 0);
      tick();
    end
    chk("mul_31_valid", bus.resp_valid, 0);
    tick();
    chk("mul_32_valid", bus.resp_valid, 1);
    chk("mul_rd",   bus.resp_rd, {32'd0, 32'd0, 32'd1, 32'h0005_000F});
    chk("mul_tag",  bus.resp_tag, 5);
    chk("mul_mask", bus.resp_mask, 4'b0111);
    bus.resp_ready = 1'b1;
    tick();
    chk("ovl_valid", bus.resp_valid, 1);
    chk("ovl_tag",   bus.resp_tag, 9);
    chk("ovl_rd",    bus.resp_rd, {4{32'd4}});
    bus.req_valid = 1'b0;
    tick();

    // back-to-back ADDs, then back-pressure
    for (int k = 0; k < 5; k++) begin
      drive(ADD, 4'hF, {4{32'(k)}}, {4{32'd100}}, 4'(k));
      tick();
      chk("b2b_valid", bus.resp_valid, 1);
      chk("b2b_tag",   bus.resp_tag, 4'(k));
      chk("b2b_rd",    bus.resp_rd, {4{32'(100 + k)}});
    end
    drive(ADD, 4'hF, {4{32'd5}}, {4{32'd100}}, 4'd5);
    bus.resp_ready = 1'b0;
    #1;
    chk("bp_ready", bus.req_ready, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("bp_tag",   bus.resp_tag, 4);
      chk("bp_rd",    bus.resp_rd, {4{32'd104}});
      chk("bp_ready", bus.req_ready, 0);
    end
    bus.resp_ready = 1'b1;
    tick();
    chk("bp_next_tag", bus.resp_tag, 5);
    chk("bp_next_rd",  bus.resp_rd, {4{32'd105}});
    bus.req_valid = 1'b0;
    tick();

    // MUL stalled 4 cycles by rdy
    bus.resp_ready = 1'b0;
    drive(MUL, 4'b0001, {{3{32'd9}}, 32'd3}, {{3{32'd9}}, 32'd4}, 4'd6);
    tick();
    bus.req_valid = 1'b0;
    got_c = 0;
    for (int c = 1; c <= 40; c++) begin
      rdy = !(c >= 10 && c <= 13);
      tick();
      if (c == 11) chk("stall_ready", bus.req_ready, 0);
      if (bus.resp_valid) begin
        got_c = c;
        break;
      end
    end
    rdy = 1'b1;
    chk("stall_latency", got_c, 36);
    chk("stall_rd", bus.resp_rd, {96'd0, 32'd12});
    bus.resp_ready = 1'b1;
    rdy = 1'b0;
    tick();
    chk("frozen_resp", bus.resp_valid, 1);
    chk("frozen_ready", bus.req_ready, 0);
    rdy = 1'b1;
    tick();
    chk("unfrozen_drain", bus.resp_valid, 0);

    // illegal opcode
    drive(4'd13, 4'hF, {4{32'h55}}, {4{32'h33}}, 4'd7);
    tick();
    chk("ill_valid", bus.resp_valid, 1);
    chk("ill_err",   bus.resp_err, 1);
    chk("ill_rd",    bus.resp_rd, 0);
    chk("ill_tag",   bus.resp_tag, 7);
    drive(XOR, 4'hF, {4{32'h55}}, {4{32'h33}}, 4'd8);
    tick();
    chk("post_ill_err", bus.resp_err, 0);
    chk("post_ill_rd",  bus.resp_rd, {4{32'h66}});
    bus.req_valid = 1'b0;
    tick();

    // reset in the middle of a MUL
    drive(MUL, 4'hF, {4{32'd3}}, {4{32'd3}}, 4'd10);
    tick();
    bus.req_valid = 1'b0;
    repeat (10) tick();
    chk("rmul_busy", bus.resp_valid, 0);
    rst_n = 1'b0;
    #1;
    chk("rmul_valid", bus.resp_valid, 0);
    chk("rmul_rd",    bus.resp_rd, 0);
    chk("rmul_tag",   bus.resp_tag, 0);
    chk("rmul_mask",  bus.resp_mask, 0);
    chk("rmul_err",   bus.resp_err, 0);
    chk("rmul_ready", bus.req_ready, 1);
    tick();
    rst_n = 1'b1;
    repeat (40) tick();
    chk("rmul_no_resp", bus.resp_valid, 0);
    drive(ADD, 4'hF, {4{32'd2}}, {4{32'd3}}, 4'd1);
    tick();
    bus.req_valid = 1'b0;
    chk("rmul_add_valid", bus.resp_valid, 1);
    chk("rmul_add_rd",    bus.resp_rd, {4{32'd5}});
    chk("rmul_add_tag",   bus.resp_tag, 1);
    tick();
    chk("rmul_add_drain", bus.resp_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
